sub64_pipelined: RTL and testbench

SUB64_PIPELINED -- requirements
Module: sub64_pipelined

---
 rtl/sub64_pipelined.sv | 95 +++++++++
 tb/tb_sub64_pipelined.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sub64_pipelined.sv
// Two-stage pipelined N-bit subtractor with valid/ready handshake.
// The low half is resolved in stage 1 and the high half in stage 2, so no borrow chain spans both halves in one cycle.
module sub64_pipelined #(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         bin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] d,
    output logic         bout,
    output logic         ovf,
    output logic         zero
);

    localparam int H = N / 2;

    logic         s1_valid_r;
    logic [H-1:0] s1_dlo_r;
    logic [H-1:0] s1_ahi_r;
    logic [H-1:0] s1_bhi_r;
    logic         s1_brw_r;

    logic         s1_load_s;
    logic         s2_load_s;
    logic [H:0]   lo_s;
    logic [H:0]   hi_s;
    logic [N-1:0] d_s;
    logic         ovf_s;
    logic         zero_s;

    // Handshake: a stage may load when it is empty or its contents move on this cycle.
    always_comb begin
        s2_load_s = !out_valid || out_ready;
        s1_load_s = !s1_valid_r || s2_load_s;
        if (rst_n) begin
            in_ready = s1_load_s;
        end else begin
            in_ready = 1'b0;
        end
    end

    // Half-width subtractions; the extra MSB of each result is the borrow out of that half.
    always_comb begin
        lo_s   = {1'b0, a[H-1:0]} - {1'b0, b[H-1:0]} - {{H{1'b0}}, bin};
        hi_s   = {1'b0, s1_ahi_r} - {1'b0, s1_bhi_r} - {{H{1'b0}}, s1_brw_r};
        d_s    = {hi_s[H-1:0], s1_dlo_r};
        ovf_s  = (s1_ahi_r[H-1] != s1_bhi_r[H-1]) && (hi_s[H-1] != s1_ahi_r[H-1]);
        zero_s = (d_s == {N{1'b0}});
    end

    // Stage 1 registers: low difference, mid borrow and the untouched upper operand halves.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            s1_dlo_r   <= {H{1'b0}};
            s1_ahi_r   <= {H{1'b0}};
            s1_bhi_r   <= {H{1'b0}};
            s1_brw_r   <= 1'b0;
        end else if (s1_load_s) begin
            s1_valid_r <= in_valid;
            if (in_valid) begin
                s1_dlo_r <= lo_s[H-1:0];
                s1_brw_r <= lo_s[H];
                s1_ahi_r <= a[N-1:H];
                s1_bhi_r <= b[N-1:H];
            end
        end
    end

    // Stage 2 registers drive the outputs directly; they only change when a valid result arrives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            d         <= {N{1'b0}};
            bout      <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
        end else if (s2_load_s) begin
            out_valid <= s1_valid_r;
            if (s1_valid_r) begin
                d    <= d_s;
                bout <= hi_s[H];
                ovf  <= ovf_s;
                zero <= zero_s;
            end
        end
    end

endmodule

// File: tb/tb_sub64_pipelined.sv
// Randomized self-checking bench for sub64_pipelined against a full-width arithmetic model.
// Directed cases pin the model with literal expectations; a negedge monitor scores every transfer.
module tb_sub64_pipelined;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] a;
    logic [63:0] b;
    logic        bin;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] d;
    logic        bout;
    logic        ovf;
    logic        zero;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_stall_cyc = -1;

    typedef struct {
        logic [63:0] d;
        logic        bout;
        logic        ovf;
        logic        zero;
        int          acc;
    } exp_t;

    exp_t        q[$];
    logic        prev_stall = 1'b0;
    logic [66:0] held;

    sub64_pipelined #(.N(64)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .d         (d),
        .bout      (bout),
        .ovf       (ovf),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: plain 65-bit arithmetic on the whole operands.
    function automatic exp_t model(input logic [63:0] ma, input logic [63:0] mb, input logic mbin, input int c);
        logic [64:0] full;
        exp_t e;
        full   = {1'b0, ma} - {1'b0, mb} - {64'd0, mbin};
        e.d    = full[63:0];
        e.bout = full[64];
        e.ovf  = (ma[63] != mb[63]) && (full[63] != ma[63]);
        e.zero = (full[63:0] == 64'd0);
        e.acc  = c;
        return e;
    endfunction

    function automatic logic [63:0] pick();
        case ($urandom_range(0, 5))
            0:       return 64'd0;
            1:       return 64'hFFFF_FFFF_FFFF_FFFF;
            2:       return 64'h8000_0000_0000_0000;
            3:       return 64'h0000_0001_0000_0000;
            default: return {$urandom(), $urandom()};
        endcase
    endfunction

    // Monitor: score every output transfer against the model queue, check hold and latency.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (!rst_n) begin
            q.delete();
            prev_stall = 1'b0;
            chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
            chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
            chk("rst_d", d, 64'd0);
            chk("rst_flags", {61'd0, bout, ovf, zero}, 64'd0);
        end else begin
            if (prev_stall) begin
                chk("hold_valid", {63'd0, out_valid}, 64'd1);
                chk("hold_d", d, held[66:3]);
                chk("hold_flags", {61'd0, bout, ovf, zero}, {61'd0, held[2:0]});
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got d=%h expected no result", d);
                end else begin
                    e = q.pop_front();
                    chk("model_d", d, e.d);
                    chk("model_flags", {61'd0, bout, ovf, zero}, {61'd0, e.bout, e.ovf, e.zero});
                    if (last_stall_cyc < e.acc)
                        chk("latency", 64'(cyc - e.acc), 64'd2);
                end
            end
            if (in_valid && in_ready)
                q.push_back(model(a, b, bin, cyc));
            if (out_valid && !out_ready) begin
                prev_stall = 1'b1;
                held = {d, bout, ovf, zero};
                last_stall_cyc = cyc;
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    task automatic run_one(input logic [63:0] ta, input logic [63:0] tb, input logic tbin,
                           input logic [63:0] ed, input logic eb, input logic eo, input logic ez,
                           input string nm);
        logic ok;
        out_ready = 1'b1;
        a = ta;
        b = tb;
        bin = tbin;
        in_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        chk({nm, "_accept"}, {63'd0, ok}, 64'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk({nm, "_valid"}, {63'd0, out_valid}, 64'd1);
        chk({nm, "_d"}, d, ed);
        chk({nm, "_flags"}, {61'd0, bout, ovf, zero}, {61'd0, eb, eo, ez});
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [10:0] ov;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = 64'd0;
        b = 64'd0;
        bin = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
        chk("reset_in_ready", {63'd0, in_ready}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("first_in_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        #1;

        run_one(64'd0, 64'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0, "zero_minus_one");
        run_one(64'h0000_0001_0000_0000, 64'd1, 1'b0, 64'h0000_0000_FFFF_FFFF, 1'b0, 1'b0, 1'b0, "half_borrow");
        run_one(64'h8000_0000_0000_0000, 64'd1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b0, "neg_ovf");
        run_one(64'd5, 64'd4, 1'b1, 64'd0, 1'b0, 1'b0, 1'b1, "bin_zero");
        run_one(64'd0, 64'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0, "bin_only");
        run_one(64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'h8000_0000_0000_0000,
                1'b1, 1'b1, 1'b0, "pos_ovf");

        // Backpressure: three sets with the consumer stalled for three cycles.
        out_ready = 1'b0;
        a = 64'd10; b = 64'd3; bin = 1'b0; in_valid = 1'b1;
        @(negedge clk); chk("bp_ready1", {63'd0, in_ready}, 64'd1);
        @(posedge clk); #1 a = 64'd7; b = 64'd7;
        @(negedge clk); chk("bp_ready2", {63'd0, in_ready}, 64'd1);
        @(posedge clk); #1 a = 64'd0; b = 64'd2;
        @(negedge clk);
        chk("bp_full_ready", {63'd0, in_ready}, 64'd0);
        chk("bp_full_valid", {63'd0, out_valid}, 64'd1);
        chk("bp_full_d", d, 64'd7);
        @(posedge clk); #1 out_ready = 1'b1;
        @(negedge clk);
        chk("bp_r1_ready", {63'd0, in_ready}, 64'd1);
        chk("bp_r1_d", d, 64'd7);
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        chk("bp_r2_d", d, 64'd0);
        chk("bp_r2_zero", {63'd0, zero}, 64'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_r3_d", d, 64'hFFFF_FFFF_FFFF_FFFE);
        chk("bp_r3_bout", {63'd0, bout}, 64'd1);
        @(posedge clk); #1;
        repeat (2) @(posedge clk);
        #1;

        // Throughput: eight sets back to back, consumer always ready.
        out_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            in_valid = (i < 8);
            a = pick();
            b = pick();
            bin = 1'($urandom_range(0, 1));
            @(negedge clk);
            ov[i] = out_valid;
            @(posedge clk);
            #1;
        end
        chk("throughput_pattern", {53'd0, ov}, {53'd0, 11'b011_1111_1100});

        // Reset while both stages hold data.
        out_ready = 1'b0;
        in_valid = 1'b1;
        a = pick(); b = pick();
        @(posedge clk); #1 a = pick(); b = pick();
        @(posedge clk); #1 in_valid = 1'b0;
        #2;
        chk("pre_reset_valid", {63'd0, out_valid}, 64'd1);
        rst_n = 1'b0;
        #1;
        chk("async_out_valid", {63'd0, out_valid}, 64'd0);
        chk("async_d", d, 64'd0);
        chk("async_in_ready", {63'd0, in_ready}, 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("post_reset_ready", {63'd0, in_ready}, 64'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("no_stale", {63'd0, out_valid}, 64'd0);
        end
        @(posedge clk); #1;
        run_one(64'd100, 64'd58, 1'b0, 64'd42, 1'b0, 1'b0, 1'b0, "after_reset");

        // Random traffic with random backpressure.
        for (int i = 0; i < 3000; i++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            a = pick();
            b = pick();
            bin = 1'($urandom_range(0, 1));
            out_ready = (i < 1500) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 1) != 0);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("drained", 64'(q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
